// File: rtl/mig_app_responder.sv
// Behavioural stand-in for the DDR3 MIG user interface backed by an on-chip 64-bit array.
// Optional MIG_RESP_BACKPRESSURE_EN adds LFSR-driven wait states on app_rdy / app_wdf_rdy.
module mig_app_responder #(
  parameter int ADDR_W      = 29,
  parameter int DEPTH_LOG2  = 10,
  parameter int RD_LATENCY  = 4,
  parameter int INIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic [2:0]        app_cmd,
  input  logic              app_en,
  output logic              app_rdy,
  input  logic [63:0]       app_wdf_data,
  input  logic [7:0]        app_wdf_mask,
  input  logic              app_wdf_wren,
  input  logic              app_wdf_end,
  output logic              app_wdf_rdy,
  output logic [63:0]       app_rd_data,
  output logic              app_rd_data_valid,
  output logic              init_calib_complete,
  output logic [7:0]        err_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic {IDLE, WR_DATA} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    buf_vld_q, buf_vld_d;
  logic [63:0]             buf_data_q, buf_data_d;
  logic [7:0]              buf_mask_q, buf_mask_d;
  logic [DEPTH_LOG2-1:0]   wr_idx_q, wr_idx_d;
  logic [RD_LATENCY-1:0]   pipe_vld_q;
  logic [DEPTH_LOG2-1:0]   pipe_idx_q [RD_LATENCY];
  logic [63:0]             rd_data_q;
  logic                    rd_vld_q;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [63:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   cmd_idx, wr_idx, src_idx;
  logic [63:0]             wr_data, rd_word;
  logic [7:0]              wr_mask;
  logic                    wr_en, rd_push, src_vld;
  logic                    init_done, rdy, wdf_rdy, cmd_acc, beat_acc;
  logic                    err_cmd, err_end;
  logic                    bp_cmd, bp_wdf;
  logic [8:0]              err_sum;
  logic                    unused_addr;

  assign cmd_idx     = app_addr[DEPTH_LOG2+2:3];
  assign unused_addr = ^{app_addr[2:0], app_addr[ADDR_W-1:DEPTH_LOG2+3]};
  assign init_done   = (cnt_q == '0);

`ifdef MIG_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign bp_cmd = (lfsr_q[1:0] == 2'b00);
  assign bp_wdf = (lfsr_q[3:2] == 2'b00);
`else
  assign bp_cmd = 1'b0;
  assign bp_wdf = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    wr_idx_d   = wr_idx_q;
    wr_en      = 1'b0;
    wr_idx     = cmd_idx;
    wr_data    = app_wdf_data;
    wr_mask    = app_wdf_mask;
    rd_push    = 1'b0;
    err_cmd    = 1'b0;
    rdy        = init_done && (state_q == IDLE) && !bp_cmd;
    wdf_rdy    = init_done && ((state_q == WR_DATA) || !buf_vld_q) && !bp_wdf;
    cmd_acc    = app_en && rdy;
    beat_acc   = app_wdf_wren && wdf_rdy;
    err_end    = beat_acc && !app_wdf_end;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          case (app_cmd)
            CMD_WR: begin
              if (buf_vld_q) begin
                wr_en     = 1'b1;
                wr_data   = buf_data_q;
                wr_mask   = buf_mask_q;
                buf_vld_d = 1'b0;
              end else if (beat_acc) begin
                wr_en = 1'b1;
              end else begin
                wr_idx_d = cmd_idx;
                state_d  = WR_DATA;
              end
            end
            CMD_RD:  rd_push = 1'b1;
            default: err_cmd = 1'b1;
          endcase
        end
        // A beat with no write command this cycle waits in the buffer
        if (beat_acc && !(cmd_acc && (app_cmd == CMD_WR))) begin
          buf_vld_d  = 1'b1;
          buf_data_d = app_wdf_data;
          buf_mask_d = app_wdf_mask;
        end
      end
      WR_DATA: begin
        if (beat_acc) begin
          wr_en   = 1'b1;
          wr_idx  = wr_idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_sum   = {1'b0, err_cnt_q} + {7'b0, err_cmd} + {7'b0, err_end};
    err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  // Output stage reads the array with same-edge write forwarding for read-after-write coherence
  assign src_vld = pipe_vld_q[RD_LATENCY-1];
  assign src_idx = pipe_idx_q[RD_LATENCY-1];
  always_comb begin
    rd_word = mem[src_idx];
    for (int b = 0; b < 8; b++) begin
      if (wr_en && (wr_idx == src_idx) && !wr_mask[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (!wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_W'(INIT_CYCLES);
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
      buf_mask_q <= '0;
      wr_idx_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_idx_q[i] <= '0;
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      wr_idx_q   <= wr_idx_d;
      pipe_vld_q[0] <= rd_push;
      pipe_idx_q[0] <= cmd_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
      rd_vld_q   <= src_vld;
      if (src_vld) rd_data_q <= rd_word;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign app_rdy             = rdy;
  assign app_wdf_rdy         = wdf_rdy;
  assign app_rd_data         = rd_data_q;
  assign app_rd_data_valid   = rd_vld_q;
  assign init_calib_complete = init_done;
  assign err_cnt             = err_cnt_q;
endmodule

// File: tb/tb_mig_app_responder.sv
// Directed self-checking bench for mig_app_responder (default parameters, no backpressure).
module tb_mig_app_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [28:0] app_addr = '0;
  logic [2:0]  app_cmd = '0;
  logic        app_en = 1'b0;
  logic        app_rdy;
  logic [63:0] app_wdf_data = '0;
  logic [7:0]  app_wdf_mask = '0;
  logic        app_wdf_wren = 1'b0;
  logic        app_wdf_end = 1'b1;
  logic        app_wdf_rdy;
  logic [63:0] app_rd_data;
  logic        app_rd_data_valid;
  logic        init_calib_complete;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  mig_app_responder dut (
    .clk(clk), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Command plus beat presented together; returns once both are accepted.
  task automatic do_write(input logic [28:0] a, input logic [63:0] d, input logic [7:0] m);
    bit cd = 0, bd = 0, oc, ob;
    app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
    for (int i = 0; i < 20 && !(cd && bd); i++) begin
      #1;
      oc = app_en && app_rdy;
      ob = app_wdf_wren && app_wdf_rdy;
      @(posedge clk); #1;
      if (oc) begin cd = 1; app_en = 1'b0; end
      if (ob) begin bd = 1; app_wdf_wren = 1'b0; end
    end
    app_en = 1'b0; app_wdf_wren = 1'b0;
    n_cmp++;
    if (!(cd && bd)) begin
      n_fail++;
      $display("FAIL write_handshake addr=%h: cmd_done=%0d beat_done=%0d, required 1/1", a, cd, bd);
    end
  endtask

  // Read; lat = cycles from accept edge to valid (-1 if none).
  task automatic do_read(input logic [28:0] a, output logic [63:0] d, output int lat);
    bit acc = 0, oc;
    d = '0; lat = -1;
    app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      oc = app_rdy;
      @(posedge clk); #1;
      if (oc) acc = 1;
    end
    app_en = 1'b0;
    if (acc) begin
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (app_rd_data_valid) begin
          lat = c; d = app_rd_data;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    bit saw_vld = 0;
    @(posedge clk); #1;
    n_cmp++; if (app_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_app_rdy: got %b want 0", app_rdy); end
    n_cmp++; if (app_wdf_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_wdf_rdy: got %b want 0", app_wdf_rdy); end
    n_cmp++; if (app_rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", app_rd_data); end
    n_cmp++; if (app_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b want 0", app_rd_data_valid); end
    n_cmp++; if (init_calib_complete !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %b want 0", init_calib_complete); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (init_calib_complete !== (k == 16)) begin
        n_fail++; $display("FAIL init_cycle_%0d: got %b want %b", k, init_calib_complete, (k == 16));
      end
      n_cmp++;
      if (app_rdy !== (k == 16)) begin
        n_fail++; $display("FAIL rdy_cycle_%0d: got %b want %b", k, app_rdy, (k == 16));
      end
      if (app_rd_data_valid) saw_vld = 1;
      if (k == 3) begin app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'h40; end
      if (k == 4) app_en = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (app_rd_data_valid) saw_vld = 1;
    end
    n_cmp++; if (saw_vld !== 1'b0) begin n_fail++; $display("FAIL early_en_ignored: got valid=1 want none"); end
  endtask

  task automatic test_write_read();
    logic [63:0] d; int lat;
    do_write(29'h40, 64'h0123456789ABCDEF, 8'h00);
    do_read(29'h40, d, lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
    n_cmp++; if (d !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rd_data_full: got %h want 0123456789abcdef", d); end
    @(posedge clk); #1;
    n_cmp++; if (app_rd_data_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse: got %b want 0", app_rd_data_valid); end
    n_cmp++; if (app_rd_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rd_data_hold: got %h want 0123456789abcdef", app_rd_data); end
  endtask

  task automatic test_masked_write();
    logic [63:0] d; int lat;
    do_write(29'h40, 64'hFFFFFFFF_00000000, 8'h0F);
    do_read(29'h40, d, lat);
    n_cmp++; if (d !== 64'hFFFFFFFF89ABCDEF) begin n_fail++; $display("FAIL masked_write: got %h want ffffffff89abcdef", d); end
    // Upper address bits alias onto the same word
    do_read(29'h40 | (29'h1 << 13) | 29'h5, d, lat);
    n_cmp++; if (d !== 64'hFFFFFFFF89ABCDEF) begin n_fail++; $display("FAIL addr_alias: got %h want ffffffff89abcdef", d); end
  endtask

  task automatic test_wr_data_wait();
    logic [63:0] d; int lat; bit oc, acc = 0;
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 29'h80;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1; oc = app_rdy;
      @(posedge clk); #1;
      if (oc) acc = 1;
    end
    app_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (app_rdy !== 1'b0) begin n_fail++; $display("FAIL wr_data_rdy_%0d: got %b want 0", k, app_rdy); end
      @(posedge clk); #1;
    end
    n_cmp++; if (app_wdf_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_data_wdf_rdy: got %b want 1", app_wdf_rdy); end
    app_wdf_wren = 1'b1; app_wdf_data = 64'hDEADBEEFCAFEF00D; app_wdf_mask = 8'h00; app_wdf_end = 1'b1;
    @(posedge clk); #1;
    app_wdf_wren = 1'b0;
    n_cmp++; if (app_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_data_return_idle: got %b want 1", app_rdy); end
    do_read(29'h80, d, lat);
    n_cmp++; if (d !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL late_beat_data: got %h want deadbeefcafef00d", d); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vdat [4];
    int vcyc [4];
    int nv = 0;
    bit rdy_ok = 1;
    for (int i = 0; i < 4; i++) do_write(29'(i * 8), 64'(i + 1), 8'h00);
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'h0;
    for (int i = 0; i < 4; i++) begin
      #1; if (app_rdy !== 1'b1) rdy_ok = 0;
      @(posedge clk); #1;
      app_addr = 29'((i + 1) * 8);
    end
    app_en = 1'b0;
    n_cmp++; if (rdy_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy: got stall want rdy every cycle"); end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (app_rd_data_valid) begin
        if (nv < 4) begin vcyc[nv] = c; vdat[nv] = app_rd_data; end
        nv++;
      end
    end
    n_cmp++; if (nv !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", nv); end
    for (int i = 0; i < 4 && i < nv; i++) begin
      n_cmp++;
      if (vcyc[i] !== i + 1 || vdat[i] !== 64'(i + 1)) begin
        n_fail++; $display("FAIL b2b_beat_%0d: got cycle %0d data %h want cycle %0d data %h", i, vcyc[i], vdat[i], i + 1, 64'(i + 1));
      end
    end
  endtask

  task automatic test_errors();
    logic [63:0] d; int lat; bit saw_vld = 0;
    app_en = 1'b1; app_cmd = 3'b111; app_addr = 29'h0;
    app_wdf_wren = 1'b1; app_wdf_data = 64'h5A5A5A5A_A5A5A5A5; app_wdf_mask = 8'h00; app_wdf_end = 1'b0;
    @(posedge clk); #1;
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b1;
    n_cmp++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL err_cnt_two: got %0d want 2", err_cnt); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (app_rd_data_valid) saw_vld = 1;
    end
    n_cmp++; if (saw_vld !== 1'b0) begin n_fail++; $display("FAIL illegal_cmd_no_valid: got valid want none"); end
    // The unterminated beat sits in the buffer and is consumed by a data-less write command
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 29'hC0;
    @(posedge clk); #1;
    app_en = 1'b0;
    n_cmp++; if (app_wdf_rdy !== 1'b1) begin n_fail++; $display("FAIL buf_cleared: got %b want 1", app_wdf_rdy); end
    do_read(29'hC0, d, lat);
    n_cmp++; if (d !== 64'h5A5A5A5A_A5A5A5A5) begin n_fail++; $display("FAIL buffered_beat_data: got %h want 5a5a5a5aa5a5a5a5", d); end
  endtask

  task automatic test_reset_inflight();
    bit saw_vld = 0;
    app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'h0;
    @(posedge clk); #1;
    app_addr = 29'h8;
    @(posedge clk); #1;
    app_en = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL async_rst_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (app_rd_data !== 64'h0) begin n_fail++; $display("FAIL async_rst_rd_data: got %h want 0", app_rd_data); end
    n_cmp++; if (init_calib_complete !== 1'b0 || app_rdy !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_init_rdy: got init=%b rdy=%b want 0/0", init_calib_complete, app_rdy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (app_rd_data_valid) saw_vld = 1;
    end
    n_cmp++; if (saw_vld !== 1'b0) begin n_fail++; $display("FAIL inflight_discarded: got valid want none"); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL post_rst_err_cnt: got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_wr_data_wait();
    test_back_to_back();
    test_errors();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
